// File: rtl/imem_fetch_ctrl.sv
// Byte-serial instruction fetch sequencer: walks four ROM bytes per instruction, assembles them
// big-endian and hands the word to the decoder over valid/ready. Optional macro: IMEM_HALT_ON_ZERO_EN.
module imem_fetch_ctrl #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_redirect,
    input  logic [31:0]       i_pc_in,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_rdata,
    output logic [31:0]       o_inst,
    output logic [31:0]       o_inst_pc,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic              o_halted,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_sr;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;

    logic [31:0] w_word;
    logic        w_halt_word;

    // The incoming byte completes the word in the same cycle it is captured.
    assign w_word = {r_sr[23:0], i_mem_rdata};

`ifdef IMEM_HALT_ON_ZERO_EN
    logic r_halted;
    assign w_halt_word = (w_word == 32'h0);
    assign o_halted    = r_halted;
`else
    assign w_halt_word = 1'b0;
    assign o_halted    = 1'b0;
`endif

    // Address wraps inside the ROM; the carry never reaches r_pc.
    assign o_mem_addr   = r_pc[ADDR_W-1:0] + ADDR_W'(r_cnt[1:0]);
    assign o_busy       = (r_state == S_FETCH);
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_inst_valid = r_inst_valid;

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_FETCH;
            r_cnt        <= 3'd0;
            r_pc         <= RESET_PC;
            r_sr         <= 32'h0;
            r_inst       <= 32'h0;
            r_inst_pc    <= RESET_PC;
            r_inst_valid <= 1'b0;
`ifdef IMEM_HALT_ON_ZERO_EN
            r_halted     <= 1'b0;
`endif
        end else if (i_redirect) begin
            r_pc         <= i_pc_in & ~32'h3;
            r_cnt        <= 3'd0;
            r_state      <= S_FETCH;
            r_inst_valid <= 1'b0;
`ifdef IMEM_HALT_ON_ZERO_EN
            r_halted     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_cnt != 3'd0) begin
                        r_sr <= w_word;
                    end
                    if (r_cnt == 3'd4) begin
                        if (w_halt_word) begin
                            r_state  <= S_HALT;
`ifdef IMEM_HALT_ON_ZERO_EN
                            r_halted <= 1'b1;
`endif
                        end else begin
                            r_inst       <= w_word;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_HOLD: begin
                    if (i_inst_ready) begin
                        r_pc         <= r_pc + 32'd4;
                        r_cnt        <= 3'd0;
                        r_inst_valid <= 1'b0;
                        r_state      <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Byte-serial instruction fetch sequencer sitting between the PC/decoder side of the rv32i core and a byte-wide, synchronous-read instruction ROM. It keeps the fetch PC, walks four consecutive byte addresses per instruction and assembles them big-endian (byte at PC = inst[31:24]). It presents each word to the decoder over a valid/ready handshake, accepts PC redirects from branch/jump logic, and stops fetching on an all-zero word, which serves as the halt marker.

## Interface

- `ADDR_W`, default 10: ROM byte-address width (1024 bytes).
- `RESET_PC`, default 32'h0: PC loaded on reset; bits [1:0] must be 0.

- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `redirect`  in  1: load `pc_in` as new fetch PC, abort current fetch.
- `pc_in`  in  32: redirect target; bits [1:0] ignored (forced to 0).
- `mem_addr`  out  ADDR_W: ROM byte address.
- `mem_rdata`  in  8: ROM byte; valid the cycle after `mem_addr` is presented.
- `inst`  out  32: assembled instruction.
- `inst_pc`  out  32: PC of `inst`.
- `inst_valid`  out  1: `inst`/`inst_pc` valid.
- `inst_ready`  in  1: decoder accepts `inst` when `inst_valid && inst_ready`.
- `halted`  out  1: zero word fetched; fetching stopped.
- `busy`  out  1: high in FETCH state.

## Operation

- State: FSM `{FETCH, HOLD, HALT}`, 3-bit counter `cnt` (0..4), 32-bit `pc`, 32-bit shift register `sr`.
- Reset values: state=FETCH, cnt=0, pc=RESET_PC, sr=0, `inst`=0, `inst_pc`=RESET_PC, `inst_valid`=0, `halted`=0, `busy`=1.
- `mem_addr` = (pc[ADDR_W-1:0] + cnt[1:0]) mod 2^ADDR_W; combinational. It wraps within the ROM and never carries into pc.
- FETCH: each cycle with cnt ≥ 1, sr ← {sr[23:0], mem_rdata}. cnt increments 0→4. At cnt=4 (last capture), the full word is sr' = {sr[23:0], mem_rdata}.
  - sr' ≠ 0, or macro off: `inst` ← sr', `inst_pc` ← pc, go to HOLD.
  - sr' = 0 with macro on: go to HALT.
- HOLD: `inst_valid`=1, `inst` stable. On handshake: pc ← pc+4 (mod 2^32), cnt ← 0, go to FETCH, `inst_valid` ← 0.
- HALT: `halted`=1, `inst_valid`=0, `mem_addr` frozen. Exit only via `redirect` or `rst`.
- `redirect` in any state has priority over everything else. It sets pc ← {pc_in[31:2],2'b00}, cnt ← 0, state ← FETCH, `inst_valid` ← 0, `halted` ← 0.
- Redirect and handshake in the same cycle: the held instruction counts as consumed, pc takes `pc_in` (not pc+4).
- `rst` in any state, including mid-fetch, restores all reset values on that edge.

## Timing

- T0 = first FETCH cycle (after reset release, handshake or redirect).
- `mem_addr` = pc+i during Ti, i=0..3. Byte i arrives in T(i+1) and is captured at the end of T(i+1).
- `inst_valid` rises in T5, so fetch latency is 5 cycles.
- With `inst_ready` held high: handshake in T5, next T0 = T6. Throughput is 1 instruction / 6 cycles.
- `halted` rises in T5 for a zero word.
- `redirect` sampled in cycle C: new pc drives `mem_addr` in C+1 (= T0).
- Outputs are registered except `mem_addr` and `busy` (decoded from state/cnt).

## Configuration

- `IMEM_HALT_ON_ZERO_EN` defined: an all-zero word enters HALT and asserts `halted`, and the word is not presented.
- Undefined: a zero word is delivered through HOLD like any other word. HALT is unreachable and `halted` is tied to 0.

## Test plan

- Reset then ROM bytes 00 90 05 13 at 0..3, `inst_ready`=1 → `mem_addr` 0,1,2,3 in T0–T3; `inst`=32'h00900513, `inst_pc`=0, `inst_valid` high in T5 only; next fetch at `mem_addr`=4 in T6.
- `inst_ready`=0 for 10 cycles after T5 → `inst`/`inst_valid` stable throughout, no address change; accepted on the first ready cycle, pc=4 next.
- Redirect to `pc_in`=32'h23 during T2 → fetch aborted; `mem_addr` 0x20 on the next cycle; `inst_pc`=0x20 five cycles later.
- Redirect coincident with handshake, `pc_in`=0x40 → next `inst_pc`=0x40, not 4; exactly one handshake counted.
- pc=0x3FC, ADDR_W=10 → `mem_addr` 0x3FC..0x3FF, then after handshake `mem_addr`=0x000 while `inst_pc`=0x400.
- Macro on, word at 8 = 0 → `halted`=1 in T5, `inst_valid` stays 0, `mem_addr` frozen; redirect to 0 clears `halted` and refetches. Macro off: same ROM delivers `inst`=0 with `inst_valid`=1.
